// File: rtl/omem_potential_store.sv
// omem_potential_store: per-SPE membrane potential and spike store.
// Write requests append to the SPE's slot sequence. Read requests return the
// potential stored in the SPE's next slot during the previous timestep.
module omem_potential_store #(
  parameter int NUM_SPE               = 5,
  parameter int SPE_BASE_ID           = 1,
  parameter int DEPTH                 = 96,
  parameter int SUM_WIDTH             = 13,
  parameter int OP_PREVIOUS_POTENTIAL = 2
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               req_valid,
  output logic                               req_ready,
  input  logic [3:0]                         req_opcode,
  input  logic [24:0]                        req_data,
  output logic                               rsp_valid,
  input  logic                               rsp_ready,
  output logic [3:0]                         rsp_dest,
  output logic [3:0]                         rsp_opcode,
  output logic [24:0]                        rsp_data,
  input  logic                               spk_rd_en,
  input  logic [$clog2(NUM_SPE*DEPTH)-1:0]   spk_rd_idx,
  output logic                               spk_rd_bit,
  output logic                               err
);

  localparam int SLOTS = NUM_SPE * DEPTH;
  localparam int IDX_W = $clog2(SLOTS);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int K_W   = (NUM_SPE > 1) ? $clog2(NUM_SPE) : 1;

  typedef enum logic [1:0] {IDLE, LOOKUP, RESP} state_t;

  // Flat slot index of SPE k's slot ptr.
  function automatic logic [IDX_W-1:0] slot_addr(input logic [K_W-1:0] k,
                                                  input logic [PTR_W-1:0] ptr);
    return IDX_W'(k) * IDX_W'(DEPTH) + IDX_W'(ptr);
  endfunction

  // Sequential pointer step, wrapping at the end of the SPE's slot range.
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  state_t state, state_next;

  logic [SUM_WIDTH-1:0] pot_mem [SLOTS];
  logic                 spk_mem [SLOTS];
  logic [SLOTS-1:0]     vld;
  logic [PTR_W-1:0]     wr_ptr [NUM_SPE];
  logic [PTR_W-1:0]     rd_ptr [NUM_SPE];

  int                   pe_int;
  logic                 legal, is_read, accept, wr_fire, rd_fire, drop;
  logic [K_W-1:0]       k_loc;
  logic [PTR_W-1:0]     wr_ptr_cur, rd_ptr_cur;
  logic [IDX_W-1:0]     wr_addr, rd_addr;

  logic [IDX_W-1:0]     addr_p1;
  logic [2:0]           dest_p1;
  logic [SUM_WIDTH-1:0] pot_rd_p2;
  logic                 vld_rd_p2;

  logic                 unused_data;
  assign unused_data = ^req_data[24:SUM_WIDTH+1];

  // Request decode: PE_ID range check, local SPE index and target slots.
  always_comb begin
    pe_int     = int'(req_opcode[3:1]);
    legal      = (pe_int >= SPE_BASE_ID) && (pe_int < SPE_BASE_ID + NUM_SPE);
    is_read    = req_opcode[0];
    k_loc      = '0;
    wr_ptr_cur = '0;
    rd_ptr_cur = '0;
    if (legal) begin
      k_loc      = K_W'(pe_int - SPE_BASE_ID);
      wr_ptr_cur = wr_ptr[k_loc];
      rd_ptr_cur = rd_ptr[k_loc];
    end
    accept  = req_valid && req_ready;
    wr_fire = accept && legal && !is_read;
    rd_fire = accept && legal && is_read;
    drop    = accept && !legal;
    wr_addr = slot_addr(k_loc, wr_ptr_cur);
    rd_addr = slot_addr(k_loc, rd_ptr_cur);
  end

  // FSM next state and response valid.
  always_comb begin
    state_next = state;
    rsp_valid  = 1'b0;
    case (state)
      IDLE:    if (rd_fire) state_next = LOOKUP;
      LOOKUP:  state_next = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM state and registered request ready (low throughout reset).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      req_ready <= 1'b0;
    end else begin
      state     <= state_next;
      req_ready <= (state_next == IDLE);
    end
  end

  // Slot valid bits, per-SPE pointers and the drop pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld <= '0;
      err <= 1'b0;
      for (int i = 0; i < NUM_SPE; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
      end
    end else begin
      err <= drop;
      if (wr_fire) begin
        vld[wr_addr]  <= 1'b1;
        wr_ptr[k_loc] <= ptr_next(wr_ptr_cur);
      end
      if (rd_fire) begin
        rd_ptr[k_loc] <= ptr_next(rd_ptr_cur);
      end
    end
  end

  // Read request capture: slot address and requester held for LOOKUP.
  always_ff @(posedge clk) begin
    if (rd_fire) begin
      addr_p1 <= rd_addr;
      dest_p1 <= req_opcode[3:1];
    end
  end

  // Potential/spike storage with synchronous read during LOOKUP.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      pot_mem[wr_addr] <= req_data[SUM_WIDTH:1];
      spk_mem[wr_addr] <= req_data[0];
    end
    if (state == LOOKUP) begin
      pot_rd_p2 <= pot_mem[addr_p1];
    end
  end

  // Response header and slot-valid qualifier, loaded in LOOKUP.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_dest   <= '0;
      rsp_opcode <= '0;
      vld_rd_p2  <= 1'b0;
    end else if (state == LOOKUP) begin
      rsp_dest   <= {1'b0, dest_p1};
      rsp_opcode <= 4'(OP_PREVIOUS_POTENTIAL);
      vld_rd_p2  <= vld[addr_p1];
    end
  end

  assign rsp_data = {{(25 - SUM_WIDTH){1'b0}}, (vld_rd_p2 ? pot_rd_p2 : '0)};

  // Spike readout, independent of the request FSM; unwritten slots read 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      spk_rd_bit <= 1'b0;
    end else if (spk_rd_en) begin
      if (int'(spk_rd_idx) < SLOTS) begin
        spk_rd_bit <= vld[spk_rd_idx] & spk_mem[spk_rd_idx];
      end else begin
        spk_rd_bit <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_omem_potential_store.sv
// Testbench for omem_potential_store: scenario tasks against a slot-array model.
module tb_omem_potential_store;

  localparam int NUM_SPE = 5;
  localparam int DEPTH   = 96;
  localparam int SLOTS   = NUM_SPE * DEPTH;
  localparam int IDX_W   = $clog2(SLOTS);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [3:0]       req_opcode = '0;
  logic [24:0]      req_data = '0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [3:0]       rsp_dest;
  logic [3:0]       rsp_opcode;
  logic [24:0]      rsp_data;
  logic             spk_rd_en = 1'b0;
  logic [IDX_W-1:0] spk_rd_idx = '0;
  logic             spk_rd_bit;
  logic             err;

  int vectors = 0;
  int miscompares = 0;

  // Model: each SPE owns DEPTH slots visited in order by its own pointers.
  int m_pot [NUM_SPE][DEPTH];
  bit m_spk [NUM_SPE][DEPTH];
  bit m_vld [NUM_SPE][DEPTH];
  int m_wp [NUM_SPE];
  int m_rp [NUM_SPE];

  omem_potential_store dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode(req_opcode), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_dest(rsp_dest), .rsp_opcode(rsp_opcode), .rsp_data(rsp_data),
    .spk_rd_en(spk_rd_en), .spk_rd_idx(spk_rd_idx), .spk_rd_bit(spk_rd_bit),
    .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  function automatic void model_reset();
    for (int k = 0; k < NUM_SPE; k++) begin
      m_wp[k] = 0;
      m_rp[k] = 0;
      for (int s = 0; s < DEPTH; s++) m_vld[k][s] = 1'b0;
    end
  endfunction

  task automatic apply_reset();
    req_valid = 1'b0; rsp_ready = 1'b0; spk_rd_en = 1'b0;
    rst_n = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    @(posedge clk); #1;
    model_reset();
  endtask

  // Present one request and hold it until accepted (bounded).
  task automatic send(input int pe, input bit rw, input logic [24:0] d);
    int n = 0;
    req_valid = 1'b1; req_opcode = {3'(pe), rw}; req_data = d;
    while (req_ready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    vectors++;
    if (n >= 50) begin
      miscompares++;
      $display("FAIL send_timeout pe=%0d req_ready=%b expected 1", pe, req_ready);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic tb_write(input int pe, input int pot, input bit spk);
    int k = pe - 1;
    send(pe, 1'b0, {11'($urandom), 13'(pot), spk});
    vectors++;
    if (req_ready !== 1'b1 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL wr_after pe=%0d ready=%b err=%b expected ready=1 err=0", pe, req_ready, err);
    end
    m_pot[k][m_wp[k]] = pot;
    m_spk[k][m_wp[k]] = spk;
    m_vld[k][m_wp[k]] = 1'b1;
    m_wp[k] = (m_wp[k] + 1) % DEPTH;
  endtask

  task automatic tb_read(input int pe, input int delay);
    int k = pe - 1;
    logic [24:0] exp = m_vld[k][m_rp[k]] ? 25'(m_pot[k][m_rp[k]]) : 25'd0;
    m_rp[k] = (m_rp[k] + 1) % DEPTH;
    send(pe, 1'b1, 25'($urandom));
    vectors++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b0 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL rd_lookup pe=%0d valid=%b ready=%b err=%b expected 0 0 0", pe, rsp_valid, req_ready, err);
    end
    @(posedge clk); #1;
    for (int i = 0; i < delay; i++) begin
      vectors++;
      if (rsp_valid !== 1'b1 || rsp_data !== exp) begin
        miscompares++;
        $display("FAIL rd_hold pe=%0d valid=%b data=%0d expected 1 %0d", pe, rsp_valid, rsp_data, exp);
      end
      @(posedge clk); #1;
    end
    vectors++;
    if (rsp_valid !== 1'b1) begin
      miscompares++; $display("FAIL rd_valid pe=%0d got=%b expected 1", pe, rsp_valid);
    end
    vectors++;
    if (rsp_dest !== 4'(pe)) begin
      miscompares++; $display("FAIL rd_dest got=%0d expected %0d", rsp_dest, pe);
    end
    vectors++;
    if (rsp_opcode !== 4'd2) begin
      miscompares++; $display("FAIL rd_opcode got=%0d expected 2", rsp_opcode);
    end
    vectors++;
    if (rsp_data !== exp) begin
      miscompares++; $display("FAIL rd_data pe=%0d got=%0d expected %0d", pe, rsp_data, exp);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    vectors++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rd_done valid=%b ready=%b expected 0 1", rsp_valid, req_ready);
    end
  endtask

  task automatic tb_spk(input int idx);
    bit exp = m_vld[idx / DEPTH][idx % DEPTH] & m_spk[idx / DEPTH][idx % DEPTH];
    spk_rd_en = 1'b1; spk_rd_idx = IDX_W'(idx);
    @(posedge clk); #1;
    spk_rd_en = 1'b0;
    vectors++;
    if (spk_rd_bit !== exp) begin
      miscompares++; $display("FAIL spk idx=%0d got=%b expected %b", idx, spk_rd_bit, exp);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    vectors++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || err !== 1'b0 || spk_rd_bit !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl ready=%b valid=%b err=%b spk=%b expected 0", req_ready, rsp_valid, err, spk_rd_bit);
    end
    vectors++;
    if (rsp_dest !== 4'd0 || rsp_opcode !== 4'd0 || rsp_data !== 25'd0) begin
      miscompares++;
      $display("FAIL reset_rsp dest=%0d op=%0d data=%0d expected 0", rsp_dest, rsp_opcode, rsp_data);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    model_reset();
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++; $display("FAIL reset_release ready=%b expected 1", req_ready);
    end
  endtask

  task automatic test_first_read();
    tb_read(1, 0);
  endtask

  task automatic test_wrap();
    tb_write(2, 70, 1'b1);
    for (int i = 0; i < 95; i++) tb_write(2, $urandom_range(0, 8191), 1'($urandom));
    tb_read(2, 0);
    tb_spk(96);
    tb_spk(96 + 95);
    // write slot 96 and read its spike in the same cycle: old bit expected
    req_valid = 1'b1; req_opcode = {3'd2, 1'b0}; req_data = {11'd0, 13'd33, 1'b0};
    spk_rd_en = 1'b1; spk_rd_idx = IDX_W'(96);
    @(posedge clk); #1;
    req_valid = 1'b0; spk_rd_en = 1'b0;
    vectors++;
    if (spk_rd_bit !== 1'b1) begin
      miscompares++; $display("FAIL spk_same_cycle got=%b expected 1", spk_rd_bit);
    end
    m_pot[1][0] = 33; m_spk[1][0] = 1'b0; m_wp[1] = 1;
    tb_spk(96);
  endtask

  task automatic test_interleave();
    apply_reset();
    tb_write(1, 5, 1'b0);
    tb_write(3, 9, 1'b1);
    tb_write(1, 6, 1'b1);
    tb_write(3, 10, 1'b0);
    tb_read(1, 0);
    tb_read(1, 0);
    tb_read(3, 0);
    tb_read(3, 0);
  endtask

  task automatic test_back_pressure();
    int v1 = $urandom_range(1, 8191);
    int v2 = $urandom_range(1, 8191);
    logic [24:0] exp;
    tb_write(1, v1, 1'b0);
    exp = m_vld[0][m_rp[0]] ? 25'(m_pot[0][m_rp[0]]) : 25'd0;
    m_rp[0] = (m_rp[0] + 1) % DEPTH;
    send(1, 1'b1, 25'd0);
    req_valid = 1'b1; req_opcode = {3'd1, 1'b0}; req_data = {11'd0, 13'(v2), 1'b1};
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      vectors++;
      if (rsp_valid !== 1'b1 || rsp_data !== exp || rsp_dest !== 4'd1 || req_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL bp_stall cyc=%0d valid=%b data=%0d dest=%0d ready=%b expected 1 %0d 1 0",
                 i, rsp_valid, rsp_data, rsp_dest, req_ready, exp);
      end
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    vectors++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_release valid=%b ready=%b expected 0 1", rsp_valid, req_ready);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    m_pot[0][m_wp[0]] = v2; m_spk[0][m_wp[0]] = 1'b1; m_vld[0][m_wp[0]] = 1'b1;
    m_wp[0] = (m_wp[0] + 1) % DEPTH;
    tb_read(1, 0);
    tb_spk(m_wp[0] - 1);
  endtask

  task automatic test_illegal();
    int bad [3] = '{7, 0, 6};
    for (int i = 0; i < 3; i++) begin
      send(bad[i], 1'(i), 25'($urandom));
      vectors++;
      if (err !== 1'b1 || rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL illegal_pulse pe=%0d err=%b valid=%b ready=%b expected 1 0 1", bad[i], err, rsp_valid, req_ready);
      end
      @(posedge clk); #1;
      vectors++;
      if (err !== 1'b0 || rsp_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL illegal_after pe=%0d err=%b valid=%b expected 0 0", bad[i], err, rsp_valid);
      end
    end
    tb_read(1, 0);
    tb_write(3, 1234, 1'b1);
    tb_read(3, 1);
  endtask

  task automatic test_reset_in_lookup();
    send(1, 1'b1, 25'd0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
      miscompares++; $display("FAIL rst_lookup valid=%b ready=%b expected 0 0", rsp_valid, req_ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      vectors++;
      if (rsp_valid !== 1'b0) begin
        miscompares++; $display("FAIL rst_no_rsp cyc=%0d valid=%b expected 0", i, rsp_valid);
      end
    end
    tb_read(1, 0);
    tb_read(3, 0);
    tb_spk(0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      int r = $urandom_range(0, 9);
      int pe = $urandom_range(1, NUM_SPE);
      if (r <= 3)      tb_write(pe, $urandom_range(0, 8191), 1'($urandom));
      else if (r <= 6) tb_read(pe, $urandom_range(0, 3));
      else if (r <= 8) tb_spk($urandom_range(0, SLOTS - 1));
      else begin
        send(7, 1'($urandom), 25'($urandom));
        vectors++;
        if (err !== 1'b1) begin
          miscompares++; $display("FAIL rand_illegal err=%b expected 1", err);
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_first_read();
    test_wrap();
    test_interleave();
    test_back_pressure();
    test_illegal();
    test_reset_in_lookup();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/omem_potential_store.md
# omem_potential_store

Clocked output-memory responder for the SNN convolution datapath. It sits behind the OMEM depacketizer/packetizer pair at node ID 12 and serves the Sum PEs (SPEs). It stores each SPE's new membrane potential and spike bit on write requests. On read requests it returns the previous timestep's potential to the requesting SPE. Per-SPE sequential pointers keep neuron order implicit, so no address is carried in the packet.

## Interface
- NUM_SPE, 5, number of SPEs served
- SPE_BASE_ID, 1, PE_ID of SPE 0; SPE k has PE_ID SPE_BASE_ID+k
- DEPTH, 96, potential slots per SPE (output neurons handled by one SPE)
- SUM_WIDTH, 13, membrane potential width
- OP_PREVIOUS_POTENTIAL, 2, opcode placed on responses
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- req_valid  in  1  request from depacketizer valid
- req_ready  out  1  request accepted when valid&&ready
- req_opcode  in  4  {PE_ID[2:0], rw}; rw=1 read, rw=0 write
- req_data  in  25  write: [13:1]=potential, [0]=spike; read: ignored
- rsp_valid  out  1  response to packetizer valid
- rsp_ready  in  1  packetizer accepts response
- rsp_dest  out  4  destination = requesting PE_ID, zero-extended
- rsp_opcode  out  4  always OP_PREVIOUS_POTENTIAL
- rsp_data  out  25  {12'b0, potential[12:0]}
- spk_rd_en  in  1  spike readout strobe
- spk_rd_idx  in  $clog2(NUM_SPE*DEPTH)  flat index k*DEPTH+slot
- spk_rd_bit  out  1  spike bit at spk_rd_idx, valid cycle after strobe
- err  out  1  one-cycle pulse on a dropped or illegal request

## Operation
- Storage: pot_mem[NUM_SPE*DEPTH] of SUM_WIDTH bits, spk_mem of 1 bit, vld[NUM_SPE*DEPTH]. Only vld is cleared by reset. A read of a slot with vld=0 returns 0.
- Per SPE k: wr_ptr[k] and rd_ptr[k], range 0..DEPTH-1, reset to 0. Each wraps DEPTH-1 -> 0 after use, so every timestep revisits the same slots in the same order.
- Local index k = PE_ID - SPE_BASE_ID. If PE_ID < SPE_BASE_ID or k >= NUM_SPE, the request is accepted and dropped: err pulses, no state change, no response.
- Write (rw=0):
  - pot_mem[k*DEPTH+wr_ptr[k]] <= req_data[13:1]
  - spk_mem[same slot] <= req_data[0]
  - vld[same slot] <= 1
  - wr_ptr[k] advances
- Read (rw=1): reads slot k*DEPTH+rd_ptr[k], rd_ptr[k] advances, and the response goes to PE_ID.
- FSM:
  - IDLE: req_ready=1. Write handshake commits and stays in IDLE. Legal read handshake -> LOOKUP.
  - LOOKUP: req_ready=0; synchronous memory read; -> RESP.
  - RESP: rsp_valid=1 with stable dest/opcode/data; req_ready=0; on rsp_ready -> IDLE.
- Only one request is ever in flight. Writes arriving while a read is outstanding stall on req_ready=0.
- A read of slot s by SPE k before SPE k's write to s in the same timestep returns the prior timestep's value. This is guaranteed because the SPE protocol always issues read then write per neuron.
- Spike readout port runs independently of the FSM. If it reads a slot written in the same cycle, it returns the old bit.

## Timing
- Reset values: req_ready=0 during reset and 1 in the first cycle after; rsp_valid=0; rsp_dest=0; rsp_opcode=0; rsp_data=0; spk_rd_bit=0; err=0. FSM=IDLE, all pointers 0, all vld 0.
- Write accepted in cycle N: memory and pointer update at the end of N; req_ready stays 1 in N+1 (1 write/cycle throughput).
- Read accepted in cycle N: LOOKUP in N+1; rsp_valid=1 from N+2 until the rsp_ready cycle. req_ready returns to 1 the cycle after the response handshake.
- rsp_ready=1 on the first RESP cycle gives 3 cycles per read.
- err pulses in cycle N+1 for a request dropped in cycle N.
- Reset asserted mid-read drops the pending response; rsp_valid=0 in the next cycle.

## Test plan
- Reset, then read from PE_ID 1 -> rsp_valid at N+2 with dest=1, opcode=2, data=0; err=0.
- Write PE_ID 2 data {13'd70,1'b1}, then 95 more writes to PE 2 (wrap), then read PE 2 -> first read returns 70. spk_rd_idx=96 (SPE 1, slot 0) returns 1.
- Interleave PE 1 and PE 3 writes of 5,6 and 9,10, then read each twice -> PE 1 gets 5,6 and PE 3 gets 9,10 in order.
- Read with rsp_ready held 0 for 10 cycles -> rsp_valid and rsp_data stay stable; a concurrent write sees req_ready=0 and commits after the response handshake.
- Request with PE_ID 7 (k=6 ≥ NUM_SPE) -> err pulse, no response, pointers unchanged.
- rst_n asserted in LOOKUP -> rsp_valid never rises. A subsequent read returns 0 because vld is cleared.
